// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared constants, state encoding and frame helper for the
// DB15 joystick responder.
package joy_db15_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int PLAYER_BITS = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } joy_state_e;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Wire image of one frame: player 1 bits first (LSB out first), then
  // player 2, inverted because the wire is active-low.
  function automatic frame_t build_frame(input logic [15:0] joy1,
                                         input logic [15:0] joy2);
    return ~{joy2[PLAYER_BITS-1:0], joy1[PLAYER_BITS-1:0]};
  endfunction

endpackage

// File: rtl/joy_sync.sv
// joy_sync: N-stage synchroniser for one asynchronous input, with a
// parameterised reset value so an idle-high line stays quiet in reset.
module joy_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/joy_db15_resp.sv
// joy_db15_resp: emulates a 74HC165-style DB15 joystick shift register.
// The reader strobes load low, then clocks out 24 active-low bits
// (player 1 bits 0..11, then player 2 bits 0..11).
// Optional link watchdog enabled by defining JOY_DB15_RESP_WDT_EN.
module joy_db15_resp
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WDT_CYCLES  = 2400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_clk_in,
  input  logic        joy_load_in,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic        joy_data_out,
  output logic        frame_done,
  output logic        link_ok
);

  localparam logic [4:0] FRAME_END = 5'(FRAME_BITS);

  logic       jclk_sync_s;
  logic       jload_sync_s;
  logic       jclk_prev_r;
  logic       jload_prev_r;
  logic       clk_rise_s;
  logic       load_rise_s;
  logic       load_fall_s;
  joy_state_e state_r;
  joy_state_e state_nxt_s;
  frame_t     shreg_r;
  frame_t     shreg_nxt_s;
  frame_t     frame_s;
  logic [4:0] bitcnt_r;
  logic [4:0] bitcnt_nxt_s;
  logic       done_nxt_s;
  logic       frame_done_r;
  logic       link_ok_r;
  logic       unused_s;

  joy_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .d     (joy_clk_in),
    .q     (jclk_sync_s)
  );

  joy_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk   (clk),
    .reset (reset),
    .d     (joy_load_in),
    .q     (jload_sync_s)
  );

  // Previous synchronised levels for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      jclk_prev_r  <= 1'b1;
      jload_prev_r <= 1'b1;
    end else begin
      jclk_prev_r  <= jclk_sync_s;
      jload_prev_r <= jload_sync_s;
    end
  end

  assign clk_rise_s  = jclk_sync_s & ~jclk_prev_r;
  assign load_rise_s = jload_sync_s & ~jload_prev_r;
  assign load_fall_s = ~jload_sync_s & jload_prev_r;
  assign frame_s     = build_frame(joystick1, joystick2);

  // Next-state and datapath: a low load overrides everything (and so wins
  // over a simultaneous clock edge); shifting only happens in SHIFT.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    done_nxt_s   = 1'b0;
    if (!jload_sync_s) begin
      state_nxt_s  = LOAD;
      shreg_nxt_s  = frame_s;
      bitcnt_nxt_s = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        LOAD: begin
          if (load_rise_s) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = LOAD;
          end
        end
        SHIFT: begin
          if (clk_rise_s) begin
            shreg_nxt_s  = {1'b1, shreg_r[FRAME_BITS-1:1]};
            bitcnt_nxt_s = bitcnt_r + 5'd1;
            if (bitcnt_nxt_s == FRAME_END) begin
              done_nxt_s  = 1'b1;
              shreg_nxt_s = '1;
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = SHIFT;
            end
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          shreg_nxt_s = '1;
        end
      endcase
    end
  end

  // State, shift register, bit counter and frame-done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      shreg_r      <= '1;
      bitcnt_r     <= 5'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shreg_r      <= shreg_nxt_s;
      bitcnt_r     <= bitcnt_nxt_s;
      frame_done_r <= done_nxt_s;
    end
  end

`ifdef JOY_DB15_RESP_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

  logic [WDT_W-1:0] wdt_cnt_r;

  // Watchdog: restart on every load fall, drop link_ok when it saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_r <= '0;
      link_ok_r <= 1'b0;
    end else if (load_fall_s) begin
      wdt_cnt_r <= '0;
      link_ok_r <= 1'b1;
    end else if (wdt_cnt_r != WDT_MAX) begin
      wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
      if (wdt_cnt_r == WDT_MAX - WDT_W'(1)) begin
        link_ok_r <= 1'b0;
      end else begin
        link_ok_r <= link_ok_r;
      end
    end else begin
      link_ok_r <= 1'b0;
    end
  end
`else
  // Without the watchdog the link is reported good whenever out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      link_ok_r <= 1'b0;
    end else begin
      link_ok_r <= 1'b1;
    end
  end
`endif

  // Unused joystick bits and helper terms kept visible as intentionally unused
  assign unused_s = ^{joystick1[15:12], joystick2[15:12], load_fall_s,
                      (WDT_CYCLES != 0)};

  assign joy_data_out = shreg_r[0];
  assign frame_done   = frame_done_r;
  assign link_ok      = link_ok_r;

endmodule

// File: doc/joy_db15_resp.md
JOY_DB15_RESP -- requirements
Module: joy_db15_resp

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on joy_clk_in and joy_load_in, legal range 2..3.
REQ-002 Parameter WDT_CYCLES, default 2400000: number of clk cycles without a load pulse before the link is declared lost (50 ms at 48 MHz).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port joy_clk_in, input, 1 bit: shift clock from the DB15 reader, asynchronous to clk.
REQ-006 Port joy_load_in, input, 1 bit: parallel-load strobe from the reader, active-low, asynchronous to clk.
REQ-007 Port joystick1, input, 16 bits: player 1 state, active-high, bit layout LS FEDCBAUDLR; only bits 11:0 are used.
REQ-008 Port joystick2, input, 16 bits: player 2 state, same layout as joystick1.
REQ-009 Port joy_data_out, output, 1 bit: serial data to the reader, active-low (0 = pressed).
REQ-010 Port frame_done, output, 1 bit: one-cycle pulse after the 24th bit has been shifted out.
REQ-011 Port link_ok, output, 1 bit: high while load pulses keep arriving within WDT_CYCLES.

Function
REQ-012 The block SHALL pass joy_clk_in and joy_load_in through SYNC_STAGES flip-flops, then one edge-detect register.
REQ-013 The frame SHALL be 24 bits in this order: joystick1[0..11], then joystick2[0..11]. Each bit SHALL be inverted on the wire.
REQ-014 The state machine SHALL have three states: IDLE, LOAD, SHIFT.
REQ-015 IDLE -> LOAD whenever the synchronised load is low, from any state.
REQ-016 In LOAD, every cycle the block SHALL reload shreg = ~{joystick2[11:0], joystick1[11:0]}, clear bitcnt to 0, and drive joy_data_out = shreg[0] (transparent load, matching a 74HC165).
REQ-017 LOAD -> SHIFT on the rising edge of the synchronised load.
REQ-018 In SHIFT, each rising edge of the synchronised clock SHALL:
  - shift shreg right with a 1 fill;
  - increment bitcnt (5 bits).
REQ-019 When bitcnt reaches 24, the block SHALL assert frame_done for exactly one cycle, hold joy_data_out at 1, and move to IDLE.
REQ-020 Further clock edges in IDLE SHALL be ignored and joy_data_out SHALL stay at 1.
REQ-021 Clock edges while load is low SHALL be ignored.
REQ-022 If a load fall and a clock rise are detected in the same cycle, the load SHALL win.
REQ-023 A load asserted mid-frame (bitcnt between 1 and 23) SHALL abort the frame without a frame_done pulse and restart it from bit 0.
REQ-024 Latency: joy_data_out SHALL update SYNC_STAGES+1 clk cycles after the joy_clk_in pin edge.
REQ-025 joy_data_out SHALL be driven straight from a register, with no combinational path from any input.
REQ-026 joystick1/joystick2 bits 15:12 SHALL have no effect on the output.

Reset
REQ-027 While reset is high, the block SHALL force:
  - state = IDLE, shreg = all-ones, bitcnt = 0;
  - joy_data_out = 1, frame_done = 0, link_ok = 0;
  - synchroniser flip-flops to 1, the watchdog counter to 0.
REQ-028 A reset asserted mid-frame SHALL take effect on the next clk edge.
REQ-029 After reset releases, the block SHALL ignore edges until the synchroniser has refilled (SYNC_STAGES cycles).

Configuration
REQ-030 Macro JOY_DB15_RESP_WDT_EN defined: a counter SHALL count clk cycles since the last synchronised load fall.
  - Each load fall sets link_ok = 1 and clears the counter.
  - When the counter reaches WDT_CYCLES, link_ok = 0 and the counter saturates.
REQ-031 Macro JOY_DB15_RESP_WDT_EN undefined: no watchdog logic exists, and link_ok SHALL be constant 1 once reset is released.

Structure
REQ-032 Package joy_db15_pkg SHALL hold:
  - constant FRAME_BITS = 24 and PLAYER_BITS = 12;
  - the state enum typedef (IDLE/LOAD/SHIFT);
  - typedef frame_t as logic [23:0].
REQ-033 Sub-module joy_sync (an N-stage synchroniser with a parameterised reset value) SHALL be instantiated once per asynchronous input.

Verification
REQ-034 Load joystick1=16'h0001, joystick2=16'h0800, then 24 clock pulses -> joy_data_out sequence 0, 1×22, 0; frame_done pulses once after pulse 24; joy_data_out=1 afterwards.
REQ-035 All inputs 0, 30 clock pulses -> 24 ones, frame_done once, pulses 25-30 ignored (no second frame_done).
REQ-036 Load, 10 clock pulses, then load again with joystick1=16'h0002 -> no frame_done, next bits 1,0,1,1... from bit 0.
REQ-037 Load fall and clock rise in the same synchronised cycle -> state LOAD, bitcnt=0, no shift.
REQ-038 Reset asserted at bitcnt=7 -> the next cycle shows joy_data_out=1, frame_done=0, link_ok=0; no shift until the next load.
REQ-039 With JOY_DB15_RESP_WDT_EN and WDT_CYCLES=100: a load every 50 cycles keeps link_ok=1; no load -> link_ok=0 exactly 100 cycles after the last load fall; the next load restores link_ok=1.
